proc_control: RTL and testbench
===============================

# proc_control

Instruction sequencer for the simple 9-bit processor datapath. It fetches an instruction word on `Run`, walks a four-step timing FSM (T0–T3), and drives the one-hot register enables, bus-source selects, ALU control and `Done` that steer the eight-register file, A/G registers and shared bus. It replaces hand-wired enable logic in the top level and consumes 3-bit register fields through the same one-hot convention as the 3-to-8 decoder.

## Interface
- No parameters; widths fixed by the 9-bit instruction format `IR[8:6]`=opcode, `IR[5:3]`=X, `IR[2:0]`=Y.
- `Clock`  in  1  rising-edge clock
- `Resetn`  in  1  asynchronous, active-low reset
- `Run`  in  1  start request, sampled in T0
- `IR`  in  9  latched instruction register contents
- `Gnz`  in  1  G register non-zero flag (used only with the configuration macro)
- `IRin`  out  1  load IR from DIN
- `Rin`  out  8  register load enables, one-hot; bit 7 = R0 … bit 0 = R7
- `Rout`  out  8  register bus-drive enables, same mapping
- `DINout`  out  1  DIN drives bus
- `Gout`  out  1  G drives bus
- `Ain`  out  1  load A from bus
- `Gin`  out  1  load G from ALU
- `AddSub`  out  1  0 = add, 1 = subtract
- `Done`  out  1  instruction completes this cycle

## Operation
- State register `Tstep` ∈ {T0, T1, T2, T3}; outputs are combinational from `Tstep`, `IR`, `Run` and `Gnz`.
- T0: `IRin` = `Run`. If `Run`=1 → T1, else stay in T0.
- Opcode 000 `mv Rx,Ry`: T1 asserts `Rout[Y]`, `Rin[X]`, `Done` → T0.
- Opcode 001 `mvi Rx,#D`: T1 asserts `DINout`, `Rin[X]`, `Done` → T0.
- Opcode 010 `add` / 011 `sub`:
  - T1: `Rout[X]`, `Ain` → T2.
  - T2: `Rout[Y]`, `Gin`; `AddSub`=0 for add, 1 for sub → T3.
  - T3: `Gout`, `Rin[X]`, `Done` → T0.
- Undefined opcodes: T1 asserts `Done` only, with no enables (NOP) → T0.
- Bus exclusivity: at most one of `Rout`, `DINout`, `Gout` is non-zero in any cycle. `Rin` and `Rout` are each zero or one-hot.
- `AddSub` is 0 in every state other than T2 of a sub.
- `Run` is ignored outside T0. Deasserting it mid-instruction does not abort the instruction.

## Timing
- Reset: while `Resetn`=0, `Tstep`=T0 and every output is 0, including `IRin`, regardless of `Run`. Release takes effect at the next rising edge.
- Reset mid-instruction: the FSM returns to T0 immediately and all enables drop in the same instant. No partial write completes after the edge on which `Resetn` is seen low.
- Latency from the `Run` edge to `Done`: mv/mvi/NOP take 1 cycle after T0 (2 cycles total); add/sub take 3 cycles after T0 (4 total).
- Back-to-back: if `Run` stays high, T0 follows `Done` and fetches again. Peak throughput is one instruction per 2 cycles.
- `IR` must be stable from T1 through `Done`; it is loaded on the T0 edge by `IRin`.
- `Done` is high for exactly one cycle per instruction.

## Configuration
- `PROC_CONTROL_MVNZ_EN` defined: opcode 100 is `mvnz Rx,Ry`.
  - T1 asserts `Done` unconditionally.
  - T1 also asserts `Rout[Y]` and `Rin[X]` only when `Gnz`=1.
  - Then → T0.
- Undefined: opcode 100 is a NOP and `Gnz` is ignored. The port remains present in both builds.

## Test plan
- Reset: hold `Resetn`=0 with `Run`=1 → all outputs 0. Drop `Resetn` mid-T2 of an add → next observation is T0 with `Rin`=0, and no `Done`.
- `mvi R2,#5`: `IR`=001_010_000, `Run` pulse → T1 shows `DINout`=1, `Rin`=8'b00100000, `Done`=1; 2 cycles total.
- `sub R1,R3`: `IR`=011_001_011 → T1 `Rout`=8'b01000000, `Ain`=1; T2 `Rout`=8'b00010000, `Gin`=1, `AddSub`=1; T3 `Gout`=1, `Rin`=8'b01000000, `Done`=1.
- Back-to-back `mv R0,R7` then `add R4,R5` with `Run` held high → `Done` at cycles 2 and 6. Bus-exclusivity assertion holds every cycle.
- Opcode 111 → `Done` in T1 with all enables 0. Opcode 100 without the macro behaves the same.
- With `PROC_CONTROL_MVNZ_EN`, `mvnz R3,R6`:
  - `Gnz`=1 → `Rout`=8'b00000010, `Rin`=8'b00010000, `Done`=1.
  - `Gnz`=0 → `Done`=1 only.

Source files
------------

// File: rtl/proc_control.sv
// rtl/proc_control.sv - T0..T3 instruction sequencer for the 9-bit processor datapath.
// Optional PROC_CONTROL_MVNZ_EN adds opcode 100 (mvnz Rx,Ry) gated by Gnz.
module proc_control (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       Gnz,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       DINout,
  output logic       Gout,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  logic [1:0] r_tstep;
  logic [1:0] w_tstep_next;
  logic [2:0] w_op;
  logic [7:0] w_x_oh;
  logic [7:0] w_y_oh;

  assign w_op = IR[8:6];
  // Register fields decode with R0 on bit 7, matching the 3-to-8 decoder.
  assign w_x_oh = 8'h80 >> IR[5:3];
  assign w_y_oh = 8'h80 >> IR[2:0];

`ifndef PROC_CONTROL_MVNZ_EN
  logic w_unused_gnz;
  assign w_unused_gnz = Gnz;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_tstep <= T0;
    end else begin
      r_tstep <= w_tstep_next;
    end
  end

  always_comb begin
    w_tstep_next = r_tstep;
    IRin   = 1'b0;
    Rin    = 8'h00;
    Rout   = 8'h00;
    DINout = 1'b0;
    Gout   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    case (r_tstep)
      T0: begin
        IRin = Run;
        if (Run) w_tstep_next = T1;
      end
      T1: begin
        w_tstep_next = T0;
        case (w_op)
          OP_MV: begin
            Rout = w_y_oh;
            Rin  = w_x_oh;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_x_oh;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout         = w_x_oh;
            Ain          = 1'b1;
            w_tstep_next = T2;
          end
`ifdef PROC_CONTROL_MVNZ_EN
          OP_MVNZ: begin
            Done = 1'b1;
            if (Gnz) begin
              Rout = w_y_oh;
              Rin  = w_x_oh;
            end
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        Rout         = w_y_oh;
        Gin          = 1'b1;
        AddSub       = (w_op == OP_SUB);
        w_tstep_next = T3;
      end
      default: begin
        Gout         = 1'b1;
        Rin          = w_x_oh;
        Done         = 1'b1;
        w_tstep_next = T0;
      end
    endcase
    // Reset masks every enable immediately, not just from the next edge.
    if (!Resetn) begin
      IRin   = 1'b0;
      Rin    = 8'h00;
      Rout   = 8'h00;
      DINout = 1'b0;
      Gout   = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - directed and randomized checks of proc_control against an instruction-level model.
module tb_proc_control;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       Gnz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int done_cyc[$];

  proc_control dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Run   (Run),
    .IR    (IR),
    .Gnz   (Gnz),
    .IRin  (IRin),
    .Rin   (Rin),
    .Rout  (Rout),
    .DINout(DINout),
    .Gout  (Gout),
    .Ain   (Ain),
    .Gin   (Gin),
    .AddSub(AddSub),
    .Done  (Done)
  );

  always #5 Clock = ~Clock;

  // Vector layout: {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
  function automatic logic [22:0] vec(logic irin, logic [7:0] rin, logic [7:0] rout,
                                      logic din, logic gout, logic ain, logic gin,
                                      logic addsub, logic done);
    return {irin, rin, rout, din, gout, ain, gin, addsub, done};
  endfunction

  function automatic logic [22:0] observed();
    return {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};
  endfunction

  function automatic logic [7:0] reg_sel(logic [2:0] r);
    logic [7:0] v;
    v = 8'h00;
    v[7 - r] = 1'b1;
    return v;
  endfunction

  function automatic bit is_mvnz(logic [2:0] op);
`ifdef PROC_CONTROL_MVNZ_EN
    return op == 3'b100;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int instr_cycles(logic [2:0] op);
    return (op == 3'b010 || op == 3'b011) ? 3 : 1;
  endfunction

  // Cycle k (1-based, after the fetch cycle) of an instruction's micro-operations.
  function automatic logic [22:0] micro_op(logic [2:0] op, logic [2:0] x, logic [2:0] y,
                                           logic gnz, int k);
    if (op == 3'b000) return vec(0, reg_sel(x), reg_sel(y), 0, 0, 0, 0, 0, 1);
    if (op == 3'b001) return vec(0, reg_sel(x), 8'h00, 1, 0, 0, 0, 0, 1);
    if (op == 3'b010 || op == 3'b011) begin
      if (k == 1) return vec(0, 8'h00, reg_sel(x), 0, 0, 1, 0, 0, 0);
      if (k == 2) return vec(0, 8'h00, reg_sel(y), 0, 0, 0, 1, op[0], 0);
      return vec(0, reg_sel(x), 8'h00, 0, 1, 0, 0, 0, 1);
    end
    if (is_mvnz(op) && gnz) return vec(0, reg_sel(x), reg_sel(y), 0, 0, 0, 0, 0, 1);
    return vec(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic check(string tag, logic [22:0] obs, logic [22:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bus(string tag);
    logic ok;
    ok = ((int'(|Rout) + int'(DINout) + int'(Gout)) <= 1) && $onehot0(Rin) && $onehot0(Rout);
    check(tag, {22'd0, ok}, 23'd1);
  endtask

  // Called just after a rising edge; samples at the following falling edge.
  task automatic sample(string tag, logic [22:0] exp);
    @(negedge Clock);
    cyc++;
    check(tag, observed(), exp);
    check_bus({tag, "_bus"});
    if (Done) done_cyc.push_back(cyc);
    @(posedge Clock);
    #1;
  endtask

  task automatic run_instr(string tag, logic [2:0] op, logic [2:0] x, logic [2:0] y, logic gnz);
    IR  = {op, x, y};
    Gnz = gnz;
    Run = 1'b1;
    sample({tag, "_t0"}, vec(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= instr_cycles(op); k++) begin
      Run = 1'($urandom);
      Gnz = (k == 1) ? gnz : 1'($urandom);
      if (k == 1) Gnz = gnz;
      sample($sformatf("%s_t%0d", tag, k), micro_op(op, x, y, gnz, k));
    end
  endtask

  task automatic idle(string tag);
    Run = 1'b0;
    IR  = 9'($urandom);
    sample(tag, 23'd0);
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = 9'b010_100_101;
    Gnz    = 1'b1;

    for (int i = 0; i < 3; i++) sample("reset_hold", 23'd0);
    Resetn = 1'b1;
    Run    = 1'b0;
    idle("idle_after_reset");

    run_instr("mvi_r2_5", 3'b001, 3'b010, 3'b000, 1'b0);
    idle("idle_a");
    run_instr("sub_r1_r3", 3'b011, 3'b001, 3'b011, 1'b0);
    idle("idle_b");
    run_instr("op111", 3'b111, 3'b101, 3'b010, 1'b1);
    run_instr("op100_gnz1", 3'b100, 3'b011, 3'b110, 1'b1);
    run_instr("op100_gnz0", 3'b100, 3'b011, 3'b110, 1'b0);
    idle("idle_c");

    done_cyc.delete();
    cyc = 0;
    run_instr("b2b_mv_r0_r7", 3'b000, 3'b000, 3'b111, 1'b0);
    run_instr("b2b_add_r4_r5", 3'b010, 3'b100, 3'b101, 1'b0);
    check("b2b_done_count", 23'(done_cyc.size()), 23'd2);
    if (done_cyc.size() == 2) begin
      check("b2b_done_first", 23'(done_cyc[0]), 23'd2);
      check("b2b_done_second", 23'(done_cyc[1]), 23'd6);
    end
    idle("idle_d");

    IR  = 9'b010_100_101;
    Run = 1'b1;
    sample("rst_add_t0", vec(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    Run = 1'b0;
    sample("rst_add_t1", micro_op(3'b010, 3'b100, 3'b101, 1'b0, 1));
    @(negedge Clock);
    check("rst_add_t2", observed(), micro_op(3'b010, 3'b100, 3'b101, 1'b0, 2));
    #1;
    Resetn = 1'b0;
    Run    = 1'b1;
    #1;
    check("rst_drop_now", observed(), 23'd0);
    @(posedge Clock);
    #1;
    check("rst_held", observed(), 23'd0);
    Resetn = 1'b1;
    Run    = 1'b0;
    sample("rst_release_t0", 23'd0);
    run_instr("post_rst_mv", 3'b000, 3'b110, 3'b001, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d_idle", i));
      run_instr($sformatf("rnd%0d_op%0d", i, op), op, 3'($urandom), 3'($urandom), 1'($urandom));
    end
    idle("idle_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
